fpu_addsub_sequencer: RTL and testbench

Multi-cycle controller for half-precision (1/5/10) floating-point add/subtract in the pipelined CPU's FPU.
- Accepts one operation per start pulse and sequences it through unpack, exponent alignment, mantissa add/sub, iterative normalization and pack.
- Alignment and left-normalization shift one bit per cycle. This trades latency for a small, low-toggle datapath, in line with the energy-efficiency goal.
- Sits between the FPU issue logic and the FP register writeback. It reports status flags with the result.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fpu_norm_step.sv | 59 +++++
 rtl/fpu_addsub_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_fpu_addsub_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the half-precision add/subtract sequencer.
package fpu_pkg;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned BIAS  = 15;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned SUM_W = MAN_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX     = '1;
  localparam logic [EXP_W-1:0] ALIGN_FLUSH = EXP_W'(SUM_W);

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StAlign,
    StAdd,
    StNorm,
    StPack,
    StDone
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } half_t;

  // Subnormals are flushed: a zero exponent yields a zero significand.
  function automatic logic [SIG_W-1:0] unpack_sig(input half_t h);
    return (h.exp == '0) ? '0 : {1'b1, h.man};
  endfunction

endpackage

// File: rtl/fpu_norm_step.sv
// One normalization step: a single right or left shift of the sum with exponent tracking.
module fpu_norm_step
  import fpu_pkg::*;
(
  input  logic [SUM_W-1:0] i_sum,
  input  logic [EXP_W-1:0] i_exp,
  output logic [SUM_W-1:0] o_sum,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_done,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic             o_zero
);

  logic [EXP_W-1:0] w_exp_inc;
  logic [EXP_W-1:0] w_exp_dec;
  logic [SUM_W-1:0] w_sum_shl;

  assign w_exp_inc = i_exp + 1'b1;
  assign w_exp_dec = i_exp - 1'b1;
  assign w_sum_shl = i_sum << 1;

  always_comb begin
    o_sum       = i_sum;
    o_exp       = i_exp;
    o_done      = 1'b0;
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    o_zero      = 1'b0;
    if (i_sum == '0) begin
      o_exp  = '0;
      o_done = 1'b1;
      o_zero = 1'b1;
    end else if (i_sum[SUM_W-1]) begin
      o_sum  = i_sum >> 1;
      o_exp  = w_exp_inc;
      o_done = 1'b1;
      if (w_exp_inc == EXP_MAX) begin
        o_overflow = 1'b1;
        o_sum      = '0;
      end
    end else if (i_sum[SUM_W-2]) begin
      o_done = 1'b1;
    end else begin
      o_sum = w_sum_shl;
      o_exp = w_exp_dec;
      // Exponent hitting zero cannot hold a normal value, so the result flushes.
      if (w_exp_dec == '0) begin
        o_sum       = '0;
        o_done      = 1'b1;
        o_underflow = 1'b1;
        o_zero      = 1'b1;
      end else begin
        o_done = w_sum_shl[SUM_W-2];
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_sequencer.sv
// Multi-cycle half-precision add/subtract: unpack, bit-serial align, add, bit-serial normalize, pack.
module fpu_addsub_sequencer
  import fpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_result,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_zero
);

  state_e           r_state;
  half_t            r_a;
  half_t            r_b;
  logic             r_sign_x;
  logic             r_sign_y;
  logic             r_sign;
  logic [SIG_W-1:0] r_sig_x;
  logic [SIG_W-1:0] r_sig_y;
  logic [EXP_W-1:0] r_exp_cnt;
  logic [EXP_W-1:0] r_diff;
  logic [SUM_W-1:0] r_sum;
  logic             r_ovf;
  logic             r_unf;
  logic             r_zero;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_result;
  logic             r_out_ovf;
  logic             r_out_unf;
  logic             r_out_zero;

  logic [SIG_W-1:0] w_sig_a;
  logic [SIG_W-1:0] w_sig_b;
  logic             w_a_special;
  logic             w_b_special;
  logic             w_a_is_x;
  logic [EXP_W-1:0] w_exp_x;
  logic [EXP_W-1:0] w_exp_y;
  logic [SUM_W-1:0] w_sum_add;
  logic [SUM_W-1:0] w_norm_sum;
  logic [EXP_W-1:0] w_norm_exp;
  logic             w_norm_done;
  logic             w_norm_ovf;
  logic             w_norm_unf;
  logic             w_norm_zero;

  assign w_sig_a     = unpack_sig(r_a);
  assign w_sig_b     = unpack_sig(r_b);
  assign w_a_special = (r_a.exp == EXP_MAX);
  assign w_b_special = (r_b.exp == EXP_MAX);
  assign w_a_is_x    = (r_a.exp > r_b.exp) || ((r_a.exp == r_b.exp) && (w_sig_a >= w_sig_b));
  assign w_exp_x     = w_a_is_x ? r_a.exp : r_b.exp;
  assign w_exp_y     = w_a_is_x ? r_b.exp : r_a.exp;
  assign w_sum_add   = (r_sign_x == r_sign_y) ? ({1'b0, r_sig_x} + {1'b0, r_sig_y})
                                              : ({1'b0, r_sig_x} - {1'b0, r_sig_y});

  fpu_norm_step u_norm_step (
    .i_sum       (r_sum),
    .i_exp       (r_exp_cnt),
    .o_sum       (w_norm_sum),
    .o_exp       (w_norm_exp),
    .o_done      (w_norm_done),
    .o_overflow  (w_norm_ovf),
    .o_underflow (w_norm_unf),
    .o_zero      (w_norm_zero)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_a        <= '0;
      r_b        <= '0;
      r_sign_x   <= 1'b0;
      r_sign_y   <= 1'b0;
      r_sign     <= 1'b0;
      r_sig_x    <= '0;
      r_sig_y    <= '0;
      r_exp_cnt  <= '0;
      r_diff     <= '0;
      r_sum      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_zero     <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_out_ovf  <= 1'b0;
      r_out_unf  <= 1'b0;
      r_out_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_a        <= i_a;
            r_b        <= {i_b[15] ^ i_op, i_b[14:0]};
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_zero     <= 1'b0;
            r_result   <= '0;
            r_out_ovf  <= 1'b0;
            r_out_unf  <= 1'b0;
            r_out_zero <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StUnpack;
          end else begin
            r_state <= StIdle;
          end
        end
        StUnpack: begin
          if (w_a_special || w_b_special) begin
            r_sign    <= w_a_special ? r_a.sign : r_b.sign;
            r_exp_cnt <= EXP_MAX;
            r_sum     <= '0;
            r_ovf     <= 1'b1;
            r_state   <= StPack;
          end else begin
            r_sign_x  <= w_a_is_x ? r_a.sign : r_b.sign;
            r_sign_y  <= w_a_is_x ? r_b.sign : r_a.sign;
            r_sig_x   <= w_a_is_x ? w_sig_a : w_sig_b;
            r_sig_y   <= w_a_is_x ? w_sig_b : w_sig_a;
            r_exp_cnt <= w_exp_x;
            r_diff    <= w_exp_x - w_exp_y;
            r_state   <= StAlign;
          end
        end
        StAlign: begin
          // Shifts of 12 or more leave nothing of Y, so skip straight to the add.
          if (r_diff >= ALIGN_FLUSH) begin
            r_sig_y <= '0;
            r_diff  <= '0;
            r_state <= StAdd;
          end else if (r_diff == '0) begin
            r_state <= StAdd;
          end else begin
            r_sig_y <= r_sig_y >> 1;
            r_diff  <= r_diff - 1'b1;
            if (r_diff == 5'd1) begin
              r_state <= StAdd;
            end
          end
        end
        StAdd: begin
          r_sum   <= w_sum_add;
          r_sign  <= r_sign_x;
          r_state <= StNorm;
        end
        StNorm: begin
          r_sum     <= w_norm_sum;
          r_exp_cnt <= w_norm_exp;
          if (r_sum == '0) begin
            r_sign <= 1'b0;
          end
          if (w_norm_ovf) r_ovf <= 1'b1;
          if (w_norm_unf) r_unf <= 1'b1;
          if (w_norm_zero) r_zero <= 1'b1;
          if (w_norm_done) r_state <= StPack;
        end
        StPack: begin
          r_result   <= {r_sign, r_exp_cnt, r_sum[MAN_W-1:0]};
          r_out_ovf  <= r_ovf;
          r_out_unf  <= r_unf;
          r_out_zero <= r_zero;
          r_done     <= 1'b1;
          r_ready    <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= StDone;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_overflow  = r_out_ovf;
  assign o_underflow = r_out_unf;
  assign o_zero      = r_out_zero;

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// Randomized self-checking bench for fpu_addsub_sequencer against an arithmetic reference model.
module tb_fpu_addsub_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;
  logic        underflow;
  logic        zero;

  int n_checks;
  int n_errors;

  fpu_addsub_sequencer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .o_ready     (ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_result    (result),
    .o_overflow  (overflow),
    .o_underflow (underflow),
    .o_zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: IEEE-half fields evaluated with integer arithmetic, truncating, FTZ.
  function automatic void ref_model(input logic [15:0] ra, input logic [15:0] rb, input logic rop,
                                    output logic [15:0] res, output logic ovf, output logic unf,
                                    output logic zr, output int nbusy);
    int sa, sb, ea, eb, ga, gb, sx, sy, ex, ey, gx, gy, d, s, e, k, align, norm;
    sa = ra[15];
    sb = rb[15] ^ rop;
    ea = ra[14:10];
    eb = rb[14:10];
    ovf = 1'b0;
    unf = 1'b0;
    zr  = 1'b0;
    if (ea == 31 || eb == 31) begin
      res   = 16'(((ea == 31) ? sa : sb) * 32768 + 31 * 1024);
      ovf   = 1'b1;
      nbusy = 2;
      return;
    end
    ga = (ea == 0) ? 0 : 1024 + int'(ra[9:0]);
    gb = (eb == 0) ? 0 : 1024 + int'(rb[9:0]);
    if (ea > eb || (ea == eb && ga >= gb)) begin
      sx = sa; ex = ea; gx = ga; sy = sb; ey = eb; gy = gb;
    end else begin
      sx = sb; ex = eb; gx = gb; sy = sa; ey = ea; gy = ga;
    end
    d = ex - ey;
    if (d >= 12) begin
      gy    = 0;
      align = 1;
    end else begin
      gy    = gy >> d;
      align = (d == 0) ? 1 : d;
    end
    s    = (sx == sy) ? gx + gy : gx - gy;
    e    = ex;
    norm = 1;
    if (s == 0) begin
      res = 16'h0000;
      zr  = 1'b1;
    end else if (s >= 2048) begin
      s = s / 2;
      e = e + 1;
      if (e == 31) begin
        ovf = 1'b1;
        res = 16'(sx * 32768 + 31 * 1024);
      end else begin
        res = 16'(sx * 32768 + e * 1024 + s % 1024);
      end
    end else begin
      k = 0;
      while (s < 1024) begin
        s = s * 2;
        k++;
      end
      if (e <= k) begin
        unf  = 1'b1;
        zr   = 1'b1;
        norm = e;
        res  = 16'(sx * 32768);
      end else begin
        norm = (k == 0) ? 1 : k;
        res  = 16'(sx * 32768 + (e - k) * 1024 + s % 1024);
      end
    end
    nbusy = 3 + align + norm;
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic top,
                        input bit poke);
    logic [15:0] e_res;
    logic        e_ovf, e_unf, e_zr;
    int          e_busy, busy_cnt, guard;
    ref_model(ta, tb_, top, e_res, e_ovf, e_unf, e_zr, e_busy);
    check_eq("ready_before", ready, 1'b1);
    a     = ta;
    b     = tb_;
    op    = top;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    op    = 1'($urandom);
    check_eq("result_cleared", result, 16'h0000);
    busy_cnt = 0;
    guard    = 0;
    while (!done && guard < 40) begin
      if (busy) busy_cnt++;
      start = (poke && guard == 1);
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    check_eq("done_seen", done, 1'b1);
    check_eq($sformatf("result %h %s %h", ta, top ? "-" : "+", tb_), result, e_res);
    check_eq("overflow", overflow, e_ovf);
    check_eq("underflow", underflow, e_unf);
    check_eq("zero", zero, e_zr);
    check_eq("busy_cycles", busy_cnt, e_busy);
    check_eq("ready_at_done", ready, 1'b1);
  endtask

  function automatic logic [15:0] small_half();
    return {1'($urandom), 5'($urandom_range(1, 4)), 10'($urandom)};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    int          done_cnt;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_result", result, 16'h0000);
    check_eq("rst_flags", {overflow, underflow, zero}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h3C00, 16'h3C00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("result_held", result, 16'h4000);
    run_op(16'h3E00, 16'h3400, 1'b0, 1'b0);
    run_op(16'h3C00, 16'h3BFF, 1'b1, 1'b0);
    run_op(16'h3C00, 16'h3C00, 1'b1, 1'b0);
    run_op(16'h7BFF, 16'h7BFF, 1'b0, 1'b0);
    run_op(16'h7C00, 16'h3C00, 1'b0, 1'b0);
    run_op(16'h0001, 16'h3C00, 1'b0, 1'b0);
    run_op(16'h0401, 16'h0400, 1'b1, 1'b0);
    run_op(16'h3C00, 16'h3BFF, 1'b1, 1'b1);
    run_op(16'hFC00, 16'h7C00, 1'b1, 1'b1);

    // Reset in the middle of a long normalization.
    a     = 16'h3C00;
    b     = 16'h3BFF;
    op    = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("abort_ready", ready, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_result", result, 16'h0000);
    done_cnt = 0;
    repeat (30) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    check_eq("abort_no_done", done_cnt, 0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          ra = 16'($urandom);
          rb = 16'($urandom);
        end
        1: begin
          ra = small_half();
          rb = small_half();
        end
        2: begin
          ra = 16'($urandom);
          rb = ra ^ 16'($urandom_range(0, 15));
        end
        default: begin
          ra = 16'($urandom);
          rb = {1'($urandom), ra[14:10] ^ 5'($urandom_range(0, 3)), 10'($urandom)};
        end
      endcase
      run_op(ra, rb, 1'($urandom), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
